// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame loader and its sibling convolver stage.
package conv_pkg;

  // Default number of samples per sequence (x and h each carry this many bits).
  localparam int unsigned CONV_LEN_DEFAULT = 4;

  // Frame loader control states.
  typedef enum logic [1:0] {
    LOAD_X  = 2'd0,
    LOAD_H  = 2'd1,
    CAPTURE = 2'd2,
    OUTPUT  = 2'd3
  } conv_state_e;

endpackage : conv_pkg

// File: rtl/conv_frame_loader.sv
// Serial frame loader: shifts in an x sequence then an h sequence bit by bit,
// presents both to an external convolver, registers its result and holds it
// for a valid/ready consumer handshake while counting completed frames.
module conv_frame_loader
  import conv_pkg::*;
#(
  parameter int unsigned LEN = CONV_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              in_data,
  output logic              in_ready,
  output logic [LEN-1:0]    x_o,
  output logic [LEN-1:0]    h_o,
  input  logic [2*LEN-1:0]  y_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*LEN-1:0]  out_y,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

  conv_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [LEN-1:0]       x_q, h_q;
  logic [2*LEN-1:0]     y_q;
  logic [7:0]           cnt_q;

  logic accept;
  logic last_bit;
  logic handshake;

  // State register; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_X;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake outputs; clear forces the frame back to LOAD_X.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    handshake = 1'b0;
    last_bit  = (idx_q == IDX_LAST);
    case (state_q)
      LOAD_X: begin
        in_ready = 1'b1;
        accept   = in_valid && !clear;
        if (accept && last_bit) state_d = LOAD_H;
      end
      LOAD_H: begin
        in_ready = 1'b1;
        accept   = in_valid && !clear;
        if (accept && last_bit) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        handshake = out_ready && !clear;
        if (handshake) state_d = LOAD_X;
      end
      default: state_d = LOAD_X;
    endcase
    if (clear) state_d = LOAD_X;
  end

  // Datapath: sequence shift-in, result capture and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      x_q   <= '0;
      h_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
      x_q   <= '0;
      h_q   <= '0;
      y_q   <= '0;
    end else begin
      case (state_q)
        LOAD_X: begin
          if (accept) begin
            x_q[idx_q] <= in_data;
            idx_q      <= last_bit ? '0 : idx_q + 1'b1;
          end
        end
        LOAD_H: begin
          if (accept) begin
            h_q[idx_q] <= in_data;
            idx_q      <= last_bit ? '0 : idx_q + 1'b1;
          end
        end
        CAPTURE: begin
          y_q <= y_i;
        end
        OUTPUT: begin
          if (handshake) begin
            idx_q <= '0;
            x_q   <= '0;
            h_q   <= '0;
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_o       = x_q;
  assign h_o       = h_q;
  assign out_y     = y_q;
  assign frame_cnt = cnt_q;

endmodule : conv_frame_loader

// File: tb/tb_conv_frame_loader.sv
// Self-checking bench for conv_frame_loader with a behavioural convolver sibling.
module tb_conv_frame_loader;

  localparam int unsigned LEN = 4;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_data;
  logic              in_ready;
  logic [LEN-1:0]    x_o;
  logic [LEN-1:0]    h_o;
  logic [2*LEN-1:0]  y_i;
  logic              out_valid;
  logic              out_ready;
  logic [2*LEN-1:0]  out_y;
  logic [7:0]        frame_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned exp_cnt  = 0;

  conv_frame_loader #(.LEN(LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .x_o       (x_o),
    .h_o       (h_o),
    .y_i       (y_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sibling convolver: carry-less product by shift-and-xor.
  function automatic logic [2*LEN-1:0] conv_shift(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    logic [2*LEN-1:0] acc;
    acc = '0;
    for (int i = 0; i < LEN; i++)
      if (b[i]) acc = acc ^ ({{LEN{1'b0}}, a} << i);
    return acc;
  endfunction

  assign y_i = conv_shift(x_o, h_o);

  // Reference: y[k] = XOR over i+j=k of x[i]&h[j].
  function automatic logic [2*LEN-1:0] ref_conv(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    logic [2*LEN-1:0] y;
    y = '0;
    for (int k = 0; k < 2*LEN; k++)
      for (int i = 0; i < LEN; i++)
        if (k - i >= 0 && k - i < LEN)
          y[k] = y[k] ^ (a[i] & b[k-i]);
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams one frame and checks the capture/output timing and result.
  task automatic run_frame(input logic [LEN-1:0] xv, input logic [LEN-1:0] hv,
                           input int unsigned gap, input string tag);
    logic [2*LEN-1:0] exp_y;
    exp_y = ref_conv(xv, hv);
    for (int k = 0; k < 2*LEN; k++) begin
      if (k > 0) begin
        for (int g = 0; g < int'(gap); g++) begin
          in_valid = 1'b0;
          in_data  = $urandom_range(0, 1);
          tick();
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_in_ready bit %0d: got %b expected 1", tag, k, in_ready);
      end
      in_valid = 1'b1;
      in_data  = (k < LEN) ? xv[k] : hv[k-LEN];
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_capture: got out_valid=%b in_ready=%b expected 0 0", tag, out_valid, in_ready);
    end
    checks++;
    if (x_o !== xv || h_o !== hv) begin
      failures++;
      $display("FAIL %s_seq: got x=%h h=%h expected x=%h h=%h", tag, x_o, h_o, xv, hv);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency: got out_valid=%b expected 1", tag, out_valid);
    end
    checks++;
    if (out_y !== exp_y) begin
      failures++;
      $display("FAIL %s_out_y: got %h expected %h", tag, out_y, exp_y);
    end
  endtask

  // Completes the pending output handshake and checks the return to loading.
  task automatic do_handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x_o !== '0 || h_o !== '0) begin
      failures++;
      $display("FAIL %s_hs_state: got in_ready=%b out_valid=%b x=%h h=%h expected 1 0 0 0",
               tag, in_ready, out_valid, x_o, h_o);
    end
    checks++;
    if (frame_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL %s_frame_cnt: got %0d expected %0d", tag, frame_cnt, exp_cnt);
    end
  endtask

  task automatic check_idle(input string tag, input logic [2*LEN-1:0] exp_y);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || x_o !== '0 || h_o !== '0 || out_y !== exp_y) begin
      failures++;
      $display("FAIL %s_idle: got out_valid=%b in_ready=%b x=%h h=%h y=%h expected 0 1 0 0 %h",
               tag, out_valid, in_ready, x_o, h_o, out_y, exp_y);
    end
    checks++;
    if (frame_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL %s_frame_cnt: got %0d expected %0d", tag, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_cnt = 0;
    check_idle("reset", '0);
  endtask

  task automatic test_basic();
    run_frame(4'b1011, 4'b0110, 0, "basic");
    checks++;
    if (out_y !== 8'h3A) begin
      failures++;
      $display("FAIL basic_3a: got %h expected 3a", out_y);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_y !== 8'h3A || in_ready !== 1'b0 || x_o !== 4'b1011 || h_o !== 4'b0110) begin
        failures++;
        $display("FAIL backpressure cycle %0d: got out_valid=%b y=%h in_ready=%b x=%h h=%h expected 1 3a 0 b 6",
                 c, out_valid, out_y, in_ready, x_o, h_o);
      end
    end
    do_handshake("backpressure");
  endtask

  task automatic test_gaps();
    run_frame(4'b1011, 4'b0110, 3, "gaps_fixed");
    do_handshake("gaps_fixed");
    for (int f = 0; f < 3; f++) begin
      run_frame(4'($urandom), 4'($urandom), 3, "gaps_rand");
      do_handshake("gaps_rand");
    end
  endtask

  task automatic test_clear_mid_frame();
    logic [LEN-1:0] xv;
    xv = 4'($urandom);
    for (int k = 0; k < LEN + 2; k++) begin
      in_valid = 1'b1;
      in_data  = (k < LEN) ? xv[k] : 1'b1;
      tick();
    end
    // clear with a coincident valid bit: the bit must be dropped
    clear = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check_idle("clear", '0);
    run_frame('1, '1, 0, "clear_ones");
    checks++;
    if (out_y !== 8'h55) begin
      failures++;
      $display("FAIL clear_ones_55: got %h expected 55", out_y);
    end
    do_handshake("clear_ones");
  endtask

  task automatic test_clear_vs_handshake();
    run_frame(4'($urandom), 4'($urandom), 0, "clr_hs");
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    check_idle("clr_hs", '0);
  endtask

  task automatic test_reset_output();
    run_frame(4'b1011, 4'b0110, 0, "rst_out");
    rst = 1'b1; clear = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; clear = 1'b0; out_ready = 1'b0;
    exp_cnt = 0;
    check_idle("rst_out", '0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 256; f++) begin
      run_frame(4'($urandom), 4'($urandom), 0, "b2b");
      do_handshake("b2b");
    end
    checks++;
    if (frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL b2b_wrap: got %0d expected 0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_clear_mid_frame();
    test_clear_vs_handshake();
    test_reset_output();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_conv_frame_loader

// File: doc/conv_frame_loader.md
CONV_FRAME_LOADER -- requirements
Module: conv_frame_loader

Interface
REQ-001 The block SHALL have parameter LEN, default 4, giving the samples per sequence; legal values are 2..8.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port clear, input, 1 bit: synchronous frame abort.
REQ-006 Port in_valid, input, 1 bit: in_data carries a valid sample bit.
REQ-007 Port in_data, input, 1 bit: serial sample bit.
REQ-008 Port in_ready, output, 1 bit: the block accepts a bit this cycle.
REQ-009 Port x_o, output, LEN bits: the x sequence driven to the downstream convolver.
REQ-010 Port h_o, output, LEN bits: the h sequence driven to the downstream convolver.
REQ-011 Port y_i, input, 2*LEN bits: the convolver's combinational result for x_o and h_o.
REQ-012 Port out_valid, output, 1 bit: out_y holds a valid result.
REQ-013 Port out_ready, input, 1 bit: the consumer accepts out_y.
REQ-014 Port out_y, output, 2*LEN bits: the registered convolution result.
REQ-015 Port frame_cnt, output, 8 bits: the count of completed output handshakes.

Function
REQ-016 The block SHALL implement four states: LOAD_X, LOAD_H, CAPTURE and OUTPUT.
REQ-017 in_ready SHALL be 1 in LOAD_X and LOAD_H, and 0 in CAPTURE and OUTPUT.
REQ-018 A bit SHALL be accepted only on a cycle where in_valid and in_ready are both 1; cycles with in_valid=0 leave all state unchanged.
REQ-019 In LOAD_X, the k-th accepted bit (k = 0..LEN-1) SHALL be written to x_o[k], LSB first; after the LEN-th bit the state SHALL become LOAD_H and the index SHALL reset to 0.
REQ-020 In LOAD_H, accepted bits SHALL be written to h_o[k], LSB first; after the LEN-th bit the state SHALL become CAPTURE.
REQ-021 CAPTURE SHALL last exactly one cycle, SHALL register y_i into out_y, and SHALL then go to OUTPUT.
REQ-022 In OUTPUT, out_valid SHALL be 1, and out_y, x_o and h_o SHALL stay stable until out_ready=1.
REQ-023 Latency: if the last h bit is accepted in cycle t, out_valid SHALL first be 1 in cycle t+2.
REQ-024 On an output handshake (out_valid and out_ready both 1), the block SHALL:
  - go to LOAD_X;
  - clear x_o, h_o and the bit index to 0;
  - increment frame_cnt modulo 256, so 255 wraps to 0.
  in_ready SHALL be 1 on the next cycle.
REQ-025 out_y SHALL carry all 2*LEN bits of y_i unmodified, with no truncation or extension.
REQ-026 clear=1 in any state SHALL, on the next cycle:
  - discard any partial frame or pending result;
  - set the state to LOAD_X and the bit index to 0;
  - set x_o, h_o and out_y to 0;
  - set out_valid to 0.
  frame_cnt SHALL be unchanged.
REQ-027 When clear=1 and in_valid=1 in the same cycle, the bit SHALL be dropped.
REQ-028 When clear=1 and an output handshake occur in the same cycle, clear SHALL win and frame_cnt SHALL NOT increment.

Reset
REQ-029 rst SHALL take priority over clear and over all handshakes.
REQ-030 After rst, the state SHALL be LOAD_X, the bit index 0, and x_o, h_o, out_y and frame_cnt all 0.
REQ-031 After rst, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-032 Asserting rst in any state, including mid-frame or during OUTPUT, SHALL produce the REQ-030/031 values on the next cycle.

Structure
REQ-033 Package conv_pkg SHALL hold the state enumeration and the default LEN constant, shared with the convolver stage.
REQ-034 The convolver SHALL stay a separate sibling instance connected through x_o, h_o and y_i; the block SHALL contain no sub-module.

Verification
REQ-035 Basic frame: with LEN=4, stream bits 1,1,0,1 then 0,1,1,0 with in_valid continuously 1 -> x_o=4'b1011, h_o=4'b0110, and out_y=8'h3A with out_valid=1 two cycles after the last bit.
REQ-036 Back-pressure: hold out_ready=0 for 5 cycles in OUTPUT -> out_valid stays 1, out_y stays 8'h3A, in_ready stays 0; raise out_ready -> in_ready=1 on the next cycle and frame_cnt=1.
REQ-037 Input gaps: insert 3 cycles of in_valid=0 between every bit -> same out_y as with a continuous stream, and no extra bit is accepted.
REQ-038 Clear mid-frame: assert clear after 2 h bits, then stream all-ones for x and h -> out_y=8'h55, and frame_cnt is unchanged by the clear.
REQ-039 Reset in OUTPUT: assert rst while out_valid=1 -> next cycle out_valid=0, out_y=0, frame_cnt=0, in_ready=1.
REQ-040 Back-to-back and wrap: run 256 frames with out_ready=1 -> frame_cnt wraps to 0, and each frame's out_y matches a carry-less product reference model.
